// File: rtl/sc_screen_bank.sv
// Screen bank for the LED matrix: stored bitmaps, row-wise load into a
// display buffer, and a blinking row scanner for the matrix driver.
module sc_screen_bank #(
  parameter int ROW_WIDTH   = 8,
  parameter int NUM_ROWS    = 8,
  parameter int NUM_SCREENS = 4,
  parameter int SEL_W       = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1,
  parameter logic [NUM_SCREENS*NUM_ROWS*ROW_WIDTH-1:0] SCREEN_DATA = {
    64'hFFFF_FFFF_FFFF_FFFF,
    64'h0024_2424_0042_3C00,
    64'h0024_2424_003C_4200,
    64'h0000_0000_0000_0000
  },
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                          SC_ScreenBank_CLOCK_50,
  input  logic                          SC_ScreenBank_RESET_InHigh,
  input  logic [SEL_W-1:0]              SC_ScreenBank_Select_In,
  input  logic                          SC_ScreenBank_Load_InLow,
  input  logic                          SC_ScreenBank_Clear_InLow,
  input  logic                          SC_ScreenBank_BlinkEnable_InHigh,
  output logic                          SC_ScreenBank_Busy_OutHigh,
  output logic                          SC_ScreenBank_Done_OutHigh,
  output logic [SEL_W-1:0]              SC_ScreenBank_Active_Out,
  output logic [NUM_ROWS*ROW_WIDTH-1:0] SC_ScreenBank_Screen_Out,
  output logic [ROW_WIDTH-1:0]          SC_ScreenBank_Row_Out,
  output logic [NUM_ROWS-1:0]           SC_ScreenBank_RowSel_Out
);

  localparam int BUF_W = NUM_ROWS * ROW_WIDTH;
  localparam int RCW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RCW-1:0] ROW_LAST = RCW'(NUM_ROWS - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [RCW-1:0]       row_q, row_d;
  logic [SEL_W-1:0]     cap_q, cap_d;
  logic [SEL_W-1:0]     act_q, act_d;
  logic                 ld_prev_q, ld_prev_d;
  logic [SCW-1:0]       scnt_q, scnt_d;
  logic [RCW-1:0]       idx_q, idx_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic                 phase_q, phase_d;
  logic [ROW_WIDTH-1:0] rout_q, rout_d;

  logic                 req;
  logic                 clr;
  logic [ROW_WIDTH-1:0] pat_row;

  assign req = ld_prev_q & ~SC_ScreenBank_Load_InLow;
  assign clr = ~SC_ScreenBank_Clear_InLow;

  // Pattern row for the captured screen; unknown screens read as blank.
  always_comb begin
    pat_row = '0;
    if (int'(cap_q) < NUM_SCREENS)
      pat_row = SCREEN_DATA[(int'(cap_q)*NUM_ROWS + int'(row_q))*ROW_WIDTH +: ROW_WIDTH];
  end

  // Load FSM: clear wins over everything, then idle/load/done sequencing.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    row_d   = row_q;
    cap_d   = cap_q;
    act_d   = act_q;
    ld_prev_d = SC_ScreenBank_Load_InLow;
    if (clr) begin
      state_d = S_IDLE;
      buf_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            state_d = S_LOAD;
            cap_d   = SC_ScreenBank_Select_In;
            row_d   = '0;
          end
        end
        S_LOAD: begin
          buf_d[int'(row_q)*ROW_WIDTH +: ROW_WIDTH] = pat_row;
          if (row_q == ROW_LAST) state_d = S_DONE;
          else row_d = row_q + 1'b1;
        end
        S_DONE: begin
          act_d   = cap_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Row scanner, blink phase and registered row output.
  always_comb begin
    scnt_d = scnt_q + 1'b1;
    idx_d  = idx_q;
    if (scnt_q == SCAN_LAST) begin
      scnt_d = '0;
      idx_d  = (idx_q == ROW_LAST) ? '0 : idx_q + 1'b1;
    end
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (!SC_ScreenBank_BlinkEnable_InHigh) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (bcnt_q == BLINK_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
    rout_d = phase_q ? buf_q[int'(idx_q)*ROW_WIDTH +: ROW_WIDTH] : '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge SC_ScreenBank_CLOCK_50) begin
    if (SC_ScreenBank_RESET_InHigh) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      row_q     <= '0;
      cap_q     <= '0;
      act_q     <= '0;
      ld_prev_q <= 1'b1;
      scnt_q    <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b1;
      rout_q    <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      row_q     <= row_d;
      cap_q     <= cap_d;
      act_q     <= act_d;
      ld_prev_q <= ld_prev_d;
      scnt_q    <= scnt_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      rout_q    <= rout_d;
    end
  end

  assign SC_ScreenBank_Busy_OutHigh = (state_q == S_LOAD);
  assign SC_ScreenBank_Done_OutHigh = (state_q == S_DONE);
  assign SC_ScreenBank_Active_Out   = act_q;
  assign SC_ScreenBank_Screen_Out   = buf_q;
  assign SC_ScreenBank_Row_Out      = rout_q;
  assign SC_ScreenBank_RowSel_Out   = NUM_ROWS'(1) << idx_q;

endmodule

// File: tb/tb_sc_screen_bank.sv
// Bench for sc_screen_bank: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_sc_screen_bank;

  localparam int RW = 8;
  localparam int NR = 8;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int SD = 2;
  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, load_n, clr_n, blink_en;
  logic [SW-1:0] sel;
  logic          busy, done;
  logic [SW-1:0] active;
  logic [63:0]   screen;
  logic [RW-1:0] row;
  logic [NR-1:0] rowsel;

  sc_screen_bank #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .SC_ScreenBank_CLOCK_50          (clk),
    .SC_ScreenBank_RESET_InHigh      (rst),
    .SC_ScreenBank_Select_In         (sel),
    .SC_ScreenBank_Load_InLow        (load_n),
    .SC_ScreenBank_Clear_InLow       (clr_n),
    .SC_ScreenBank_BlinkEnable_InHigh(blink_en),
    .SC_ScreenBank_Busy_OutHigh      (busy),
    .SC_ScreenBank_Done_OutHigh      (done),
    .SC_ScreenBank_Active_Out        (active),
    .SC_ScreenBank_Screen_Out        (screen),
    .SC_ScreenBank_Row_Out           (row),
    .SC_ScreenBank_RowSel_Out        (rowsel)
  );

  // Row tables, row 0 first.
  logic [7:0] pat [NS][NR] = '{
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h42, 8'h3C, 8'h00, 8'h24, 8'h24, 8'h24, 8'h00},
    '{8'h00, 8'h3C, 8'h42, 8'h00, 8'h24, 8'h24, 8'h24, 8'h00},
    '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}
  };

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Behavioural model: rows loaded so far, cycle counts for scan/blink.
  logic [7:0]  m_buf [NR];
  int          m_pos = -1;
  int          m_sel = 0;
  int          m_act = 0;
  bit          m_prev = 1;
  int          m_n = 0;
  int          m_e = 0;
  logic [7:0]  m_row = 0;
  bit          m_ok = 0;
  logic [63:0] m_scr;
  logic [7:0]  m_nrow;
  bit          m_req;

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NR; i++) m_buf[i] = 8'h00;
      m_pos = -1; m_sel = 0; m_act = 0; m_prev = 1;
      m_n = 0; m_e = 0; m_row = 8'h00; m_ok = 1;
    end else begin
      m_nrow = (((m_e / BD) % 2) == 0) ? m_buf[(m_n / SD) % NR] : 8'h00;
      m_req = m_prev && !load_n;
      if (!clr_n) begin
        for (int i = 0; i < NR; i++) m_buf[i] = 8'h00;
        m_pos = -1;
      end else if (m_pos < 0) begin
        if (m_req) begin m_pos = 0; m_sel = int'(sel); end
      end else if (m_pos < NR) begin
        m_buf[m_pos] = (m_sel < NS) ? pat[m_sel][m_pos] : 8'h00;
        m_pos++;
      end else begin
        m_act = m_sel;
        m_pos = -1;
      end
      m_prev = load_n;
      m_n++;
      m_e = blink_en ? m_e + 1 : 0;
      m_row = m_nrow;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      for (int i = 0; i < NR; i++) m_scr[i*8 +: 8] = m_buf[i];
      chk("m_busy", 64'(busy), 64'(m_pos >= 0 && m_pos < NR));
      chk("m_done", 64'(done), 64'(m_pos == NR));
      chk("m_active", 64'(active), 64'(m_act));
      chk("m_screen", screen, m_scr);
      chk("m_rowsel", 64'(rowsel), 64'(1) << ((m_n / SD) % NR));
      chk("m_row", 64'(row), 64'(m_row));
    end
  end

  int bc, dc, di, cnt;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int s);
    sel = SW'(s);
    load_n = 0;
    @(negedge clk);
    load_n = 1;
    cyc(12);
  endtask

  task automatic watch(input int n);
    bc = 0; dc = 0; di = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin dc++; di = i; end
    end
  endtask

  initial begin
    rst = 1; load_n = 1; clr_n = 1; blink_en = 0; sel = '0;
    cyc(2);
    chk("rst_screen", screen, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_active", 64'(active), 64'h0);
    chk("rst_rowsel", 64'(rowsel), 64'h01);
    chk("rst_row", 64'(row), 64'h00);
    rst = 0;
    cyc(3);

    sel = 2'd1; load_n = 0;
    watch(20);
    chk("lose_busy_cycles", 64'(bc), 64'd8);
    chk("lose_done_count", 64'(dc), 64'd1);
    chk("lose_done_pos", 64'(di), 64'd8);
    chk("lose_screen", screen, 64'h0024242400_3C4200);
    chk("lose_active", 64'(active), 64'd1);
    load_n = 1;
    cyc(2);

    do_load(2);
    chk("win_screen", screen, 64'h0024242400_423C00);
    chk("win_active", 64'(active), 64'd2);
    cnt = 0; dc = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (rowsel == 8'h80) cnt++;
      if (row == 8'h24) dc++;
    end
    chk("scan_row7_cycles", 64'(cnt), 64'd4);
    chk("scan_24_cycles", 64'(dc), 64'd12);

    do_load(3);
    blink_en = 1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (row == 8'hFF) cnt++;
    end
    chk("blink_on_cycles", 64'(cnt), 64'd8);
    blink_en = 0;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("blink_off_steady", 64'(row), 64'hFF);
    end

    do_load(2);
    sel = 2'd3; load_n = 0;
    @(negedge clk);
    load_n = 1;
    cyc(2);
    clr_n = 0;
    @(negedge clk);
    chk("clr_screen", screen, 64'h0);
    chk("clr_busy", 64'(busy), 64'h0);
    clr_n = 1;
    watch(12);
    chk("clr_no_done", 64'(dc), 64'd0);
    chk("clr_active", 64'(active), 64'd2);

    clr_n = 0; load_n = 0; sel = 2'd1;
    @(negedge clk);
    clr_n = 1;
    watch(10);
    chk("clrload_no_busy", 64'(bc), 64'd0);
    chk("clrload_screen", screen, 64'h0);
    load_n = 1;
    cyc(1);

    sel = 2'd1; load_n = 0;
    @(negedge clk);
    load_n = 1;
    cyc(4);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstmid_screen", screen, 64'h0);
    chk("rstmid_busy", 64'(busy), 64'h0);
    chk("rstmid_active", 64'(active), 64'h0);
    chk("rstmid_rowsel", 64'(rowsel), 64'h01);
    chk("rstmid_row", 64'(row), 64'h00);
    sel = 2'd2; load_n = 0;
    watch(12);
    chk("post_busy_cycles", 64'(bc), 64'd8);
    chk("post_done_count", 64'(dc), 64'd1);
    chk("post_screen", screen, 64'h0024242400_423C00);
    load_n = 1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) < 3) load_n = ~load_n;
      clr_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
      sel = SW'($urandom_range(0, 3));
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 0; load_n = 1; clr_n = 1;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_screen_bank.md
Name: sc_screen_bank

Overview:
- Parametrised successor to the fixed single-pattern LOSE register.
- Holds NUM_SCREENS selectable bitmaps (blank, LOSE, WIN, all-on by default) for the LED matrix.
- Copies the selected screen into a display buffer, one row per clock, using a load/busy/done handshake.
- Scans the buffer row by row onto the matrix driver, with optional blinking; sits between game control FSM and matrix driver.

Parameters:
- ROW_WIDTH, 8, bits per matrix row.
- NUM_ROWS, 8, rows per screen.
- NUM_SCREENS, 4, number of stored screens; SEL_W = max(1, clog2(NUM_SCREENS)).
- SCREEN_DATA, see Behaviour, NUM_SCREENS*NUM_ROWS*ROW_WIDTH-bit packed patterns; screen s row r at bits [(s*NUM_ROWS+r)*ROW_WIDTH +: ROW_WIDTH].
- SCAN_DIV, 50000, clock cycles per scanned row (>=1).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=1).

Ports:
- SC_ScreenBank_CLOCK_50  in  1  system clock.
- SC_ScreenBank_RESET_InHigh  in  1  synchronous reset, active-high.
- SC_ScreenBank_Select_In  in  SEL_W  screen index to load.
- SC_ScreenBank_Load_InLow  in  1  load request, active-low, falling-edge triggered.
- SC_ScreenBank_Clear_InLow  in  1  level clear of buffer, active-low.
- SC_ScreenBank_BlinkEnable_InHigh  in  1  enable blink of scanned output.
- SC_ScreenBank_Busy_OutHigh  out  1  high while rows are being copied.
- SC_ScreenBank_Done_OutHigh  out  1  one-cycle pulse at end of load.
- SC_ScreenBank_Active_Out  out  SEL_W  index of last fully loaded screen.
- SC_ScreenBank_Screen_Out  out  NUM_ROWS*ROW_WIDTH  whole display buffer, row r at [r*ROW_WIDTH +: ROW_WIDTH].
- SC_ScreenBank_Row_Out  out  ROW_WIDTH  data of currently scanned row.
- SC_ScreenBank_RowSel_Out  out  NUM_ROWS  one-hot active-high row select.

Behaviour:
- Default SCREEN_DATA, rows 7..0:
  - Screen 0: all 00.
  - Screen 1 (LOSE): 00,24,24,24,00,3C,42,00.
  - Screen 2 (WIN): 00,24,24,24,00,42,3C,00.
  - Screen 3: all FF.
- Reset, synchronous to the clock edge:
  - Buffer all 0; FSM IDLE; Busy=0; Done=0; Active=0.
  - Scan index=0, so RowSel=1 and Row_Out=0.
  - Scan and blink prescalers=0; blink phase=ON; Load edge register=1.
- Load edge detection: a request occurs when the previous sample of Load_InLow=1 and the current sample=0. Holding Load low gives one load only.
- FSM:
  - IDLE -> LOAD on a request when Clear_InLow=1. Select is captured into a working register and row counter=0.
  - LOAD: each cycle buffer[row] <= pattern[captured][row] and row increments. Busy=1 throughout.
  - After row NUM_ROWS-1 is written, -> DONE. A load therefore spans exactly NUM_ROWS cycles.
  - DONE: Done=1, Busy=0, Active <= captured index, for one cycle, then -> IDLE.
  - Requests arriving while in LOAD or DONE are dropped, not queued.
- Select >= NUM_SCREENS (non-power-of-two counts) loads all-zero rows; Active still records the index.
- Clear_InLow=0 in any state:
  - Next edge zeroes the buffer and aborts any load (-> IDLE, Busy=0, no Done pulse).
  - Active is unchanged.
  - Clear has priority over a same-cycle Load request; that request is discarded.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1; on terminal count the scan index increments, wrapping NUM_ROWS-1 -> 0.
  - RowSel = 1 << index.
  - Row_Out is registered: it is buffer[index] of the previous cycle, gated by blink. A row updated mid-scan appears one cycle later.
- Blink:
  - With BlinkEnable=1, the prescaler counts 0..BLINK_DIV-1 and toggles the phase on terminal count.
  - Phase OFF forces Row_Out=0. Screen_Out and RowSel are not blanked.
  - BlinkEnable=0 holds the prescaler at 0 and phase=ON.
- Reset mid-load: all state returns to reset values on that edge and the partial load is discarded.

Test Plan:
- Directed-test parameters: SCAN_DIV=2, BLINK_DIV=4, defaults otherwise.
- Reset: hold RESET_InHigh 2 cycles -> Screen_Out=0, Busy=0, Done=0, Active=0, RowSel=8'b00000001, Row_Out=00.
- LOSE load: Select=1, Load low at edge k and held low 20 cycles -> Busy=1 for edges k+1..k+8, Done=1 only at k+9, Screen_Out=64'h0024242400_3C4200, Active=1, no second load.
- Scan wrap after WIN load: RowSel goes 01,02,...,80,01, each value held 2 cycles; Row_Out follows 00,3C,42,00,24,24,24,00 (rows 0..7) with one-cycle lag.
- Blink: BlinkEnable=1 on screen 3 -> Row_Out alternates FF for 4 cycles, 00 for 4 cycles; BlinkEnable=0 -> Row_Out=FF steadily.
- Clear mid-load: Load screen 3, Clear low at 3rd LOAD cycle -> next edge Screen_Out=0, Busy=0, no Done pulse, Active unchanged. Clear low together with a Load request -> no load starts.
- Reset mid-load: RESET_InHigh at 5th LOAD cycle -> all reset values. A later Load of screen 2 completes normally with Done after 8 Busy cycles.
